// File: rtl/multicycle_control.sv
// Multicycle control unit: accepts one instruction in IDLE, decodes it in a
// single EXEC cycle, and for loads/stores waits in MEM_WAIT for the memory
// acknowledge (bounded by TIMEOUT cycles). Strobes are decoded from the
// registered state and latched instruction so branch conditions use the
// flags present during the EXEC cycle.
module multicycle_control #(
  parameter int INST_W     = 9,
  parameter int REG_W      = 4,
  parameter int SIGNED_CMP = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inst_valid,
  input  logic [INST_W-1:0] inst,
  output logic              inst_ready,
  input  logic              z,
  input  logic              c,
  input  logic              n,
  input  logic              v,
  input  logic              mem_ack,
  output logic              memory_read_en,
  output logic              memory_write_en,
  output logic              reg_write_en,
  output logic              reg_to_reg,
  output logic              branch_en,
  output logic              fetch_acc_en,
  output logic [REG_W-1:0]  reg_write_number,
  output logic [REG_W-1:0]  reg_from_number,
  output logic              busy,
  output logic              illegal,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t            state;
  logic [INST_W-1:0] inst_q;
  logic [CNT_W-1:0]  wait_cnt;

  // Instruction fields of the latched word
  logic             cls;
  logic [2:0]       bop;
  logic [3:0]       op;
  logic [REG_W-1:0] r;
  logic             is_mem;
  logic             is_load;
  logic             lt;
  logic             timed_out;

  // Carry is not used by any branch condition; v only matters for signed compare
  logic [1:0] unused_flags;
  assign unused_flags = {c, v};

  assign cls       = inst_q[INST_W-1];
  assign bop       = inst_q[INST_W-2 -: 3];
  assign op        = inst_q[INST_W-2 -: 4];
  assign r         = inst_q[REG_W-1:0];
  assign is_mem    = ~cls & (op[3:1] == 3'b000);
  assign is_load   = ~op[0];
  assign lt        = (SIGNED_CMP != 0) ? (n ^ v) : n;
  // The error cycle follows TIMEOUT full wait cycles without an acknowledge
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT));

  // State, latched instruction and memory wait counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      inst_q   <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_valid) begin
            inst_q <= inst;
            state  <= EXEC;
          end
        end
        EXEC: begin
          wait_cnt <= '0;
          state    <= is_mem ? MEM_WAIT : IDLE;
        end
        MEM_WAIT: begin
          if (timed_out || mem_ack) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath strobes decoded from state, latched instruction and live flags
  always_comb begin
    inst_ready       = reset_n & (state == IDLE);
    busy             = (state != IDLE);
    memory_read_en   = 1'b0;
    memory_write_en  = 1'b0;
    reg_write_en     = 1'b0;
    reg_to_reg       = 1'b0;
    branch_en        = 1'b0;
    fetch_acc_en     = 1'b0;
    illegal          = 1'b0;
    mem_err          = 1'b0;
    reg_write_number = '0;
    reg_from_number  = '0;
    case (state)
      EXEC: begin
        if (cls) begin
          case (bop)
            3'b000:  branch_en = lt & ~z;
            3'b001:  branch_en = ~lt & ~z;
            3'b010:  branch_en = z;
            3'b011:  branch_en = 1'b1;
            3'b101:  branch_en = ~lt | z;
            3'b110:  branch_en = lt | z;
            3'b100: begin
              fetch_acc_en = 1'b1;
              reg_write_en = 1'b1;
            end
            default: illegal = 1'b1;
          endcase
        end else begin
          case (op)
            4'b0000: begin
              memory_read_en  = 1'b1;
              reg_from_number = r;
            end
            4'b0001: begin
              memory_write_en = 1'b1;
              reg_from_number = r;
            end
            4'b1100: begin
              reg_write_en     = 1'b1;
              reg_to_reg       = 1'b1;
              reg_write_number = r;
            end
            4'b1101: begin
              reg_write_en    = 1'b1;
              reg_to_reg      = 1'b1;
              reg_from_number = r;
            end
            default: begin
              reg_write_en    = 1'b1;
              reg_from_number = r;
            end
          endcase
        end
      end
      MEM_WAIT: begin
        reg_from_number = r;
        if (timed_out) begin
          mem_err = 1'b1;
        end else begin
          memory_read_en  = is_load;
          memory_write_en = ~is_load;
          reg_write_en    = is_load & mem_ack;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table of single-cycle instruction vectors,
// hand-written memory/reset sequences, and randomized traffic compared
// against a behavioural model of the instruction set.
module tb_multicycle_control;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset_n, inst_valid, z, c, n, v, mem_ack;
  logic [8:0] inst;

  logic       inst_ready, memory_read_en, memory_write_en, reg_write_en, reg_to_reg;
  logic       branch_en, fetch_acc_en, busy, illegal, mem_err;
  logic [3:0] reg_write_number, reg_from_number;

  logic       u_inst_ready, u_memory_read_en, u_memory_write_en, u_reg_write_en, u_reg_to_reg;
  logic       u_branch_en, u_fetch_acc_en, u_busy, u_illegal, u_mem_err;
  logic [3:0] u_reg_write_number, u_reg_from_number;

  logic [17:0] obs, obs_u;

  int total  = 0;
  int passed = 0;

  localparam logic [17:0] IDLE_V = 18'h20000;

  always #5 clk = ~clk;

  multicycle_control #(.INST_W(9), .REG_W(4), .SIGNED_CMP(1), .TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .inst_valid(inst_valid), .inst(inst),
    .inst_ready(inst_ready), .z(z), .c(c), .n(n), .v(v), .mem_ack(mem_ack),
    .memory_read_en(memory_read_en), .memory_write_en(memory_write_en),
    .reg_write_en(reg_write_en), .reg_to_reg(reg_to_reg), .branch_en(branch_en),
    .fetch_acc_en(fetch_acc_en), .reg_write_number(reg_write_number),
    .reg_from_number(reg_from_number), .busy(busy), .illegal(illegal), .mem_err(mem_err)
  );

  multicycle_control #(.INST_W(9), .REG_W(4), .SIGNED_CMP(0), .TIMEOUT(T)) dut_u (
    .clk(clk), .reset_n(reset_n), .inst_valid(inst_valid), .inst(inst),
    .inst_ready(u_inst_ready), .z(z), .c(c), .n(n), .v(v), .mem_ack(mem_ack),
    .memory_read_en(u_memory_read_en), .memory_write_en(u_memory_write_en),
    .reg_write_en(u_reg_write_en), .reg_to_reg(u_reg_to_reg), .branch_en(u_branch_en),
    .fetch_acc_en(u_fetch_acc_en), .reg_write_number(u_reg_write_number),
    .reg_from_number(u_reg_from_number), .busy(u_busy), .illegal(u_illegal), .mem_err(u_mem_err)
  );

  assign obs = {inst_ready, busy, memory_read_en, memory_write_en, reg_write_en, reg_to_reg,
                branch_en, fetch_acc_en, illegal, mem_err, reg_write_number, reg_from_number};
  assign obs_u = {u_inst_ready, u_busy, u_memory_read_en, u_memory_write_en, u_reg_write_en,
                  u_reg_to_reg, u_branch_en, u_fetch_acc_en, u_illegal, u_mem_err,
                  u_reg_write_number, u_reg_from_number};

  // Expected EXEC-cycle output vector from individual fields
  function automatic logic [17:0] mk(input bit rw, r2r, br, fa, ill, input logic [3:0] wn, fn);
    return {1'b0, 1'b1, 1'b0, 1'b0, rw, r2r, br, fa, ill, 1'b0, wn, fn};
  endfunction

  // Behavioural model of one non-memory instruction in its EXEC cycle
  function automatic logic [17:0] model_exec(input logic [8:0] i, input bit zf, nf, vf, sgn);
    int  cls, op, bop, r;
    bit  lt, take;
    logic [17:0] res;
    cls = i[8]; op = i[7:4]; bop = i[7:5]; r = i[3:0];
    lt  = sgn ? (nf != vf) : nf;
    res = mk(0, 0, 0, 0, 0, 4'd0, 4'd0);
    take = 0;
    if (cls == 1) begin
      case (bop)
        0: take = lt && !zf;
        1: take = !lt && !zf;
        2: take = zf;
        3: take = 1;
        5: take = !lt || zf;
        6: take = lt || zf;
        4: res = mk(1, 0, 0, 1, 0, 4'd0, 4'd0);
        default: res = mk(0, 0, 0, 0, 1, 4'd0, 4'd0);
      endcase
      if (bop != 4 && bop != 7) res = mk(0, 0, take, 0, 0, 4'd0, 4'd0);
    end else if (op == 12) res = mk(1, 1, 0, 0, 0, 4'(r), 4'd0);
    else if (op == 13)     res = mk(1, 1, 0, 0, 0, 4'd0, 4'(r));
    else                   res = mk(1, 0, 0, 0, 0, 4'd0, 4'(r));
    return res;
  endfunction

  // Expected vector for a memory instruction: EXEC (w<0) or wait cycle w
  function automatic logic [17:0] model_mem(input bit load, input logic [3:0] r, input bit ack);
    return {1'b0, 1'b1, load, !load, load && ack, 5'b0, 4'd0, r};
  endfunction

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+4 of an IDLE cycle, leaves at posedge+4 of the next IDLE cycle
  task automatic run_nonmem(input logic [8:0] i, input bit zf, nf, vf,
                            input logic [17:0] exp, input logic [17:0] exp_u, input string name);
    inst_valid = 1'b1;
    inst = i;
    step();
    inst_valid = 1'b0;
    inst = 9'($urandom);
    z = zf; n = nf; v = vf; c = 1'($urandom);
    #3;
    check(name, obs, exp);
    check({name, "_u"}, obs_u, exp_u);
    step();
    #3;
    check({name, "_idle"}, obs, IDLE_V);
  endtask

  // Memory access with acknowledge in wait cycle d (d >= T: never acknowledged in time)
  task automatic run_mem(input logic [8:0] i, input int d, input string name);
    bit load;
    load = (i[4] == 1'b0);
    inst_valid = 1'b1;
    inst = i;
    step();
    inst_valid = 1'b0;
    #3;
    check({name, "_exec"}, obs, model_mem(load, i[3:0], 1'b0));
    for (int w = 0; w <= T; w++) begin
      step();
      mem_ack = (w == d);
      #3;
      if (w < T) begin
        check($sformatf("%s_w%0d", name, w), obs, model_mem(load, i[3:0], w == d));
        if (w == d) break;
      end else begin
        check({name, "_timeout"}, {obs[17:4], 4'd0}, {14'b01_0000_0001_0000, 4'd0});
      end
    end
    step();
    mem_ack = 1'b0;
    #3;
    check({name, "_idle"}, obs, IDLE_V);
  endtask

  typedef struct {
    logic [8:0]  inst;
    logic        zf, nf, vf;
    logic [17:0] exp;
    logic        br_u;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [17:0] eu;
    logic [8:0]  ri;
    bit          rz, rn, rv;

    vecs[0]  = '{9'b0_0010_0101, 0, 0, 0, mk(1, 0, 0, 0, 0, 4'd0, 4'd5), 0};
    vecs[1]  = '{9'b1_000_00011, 0, 1, 0, mk(0, 0, 1, 0, 0, 4'd0, 4'd0), 1};
    vecs[2]  = '{9'b1_000_00011, 1, 1, 0, mk(0, 0, 0, 0, 0, 4'd0, 4'd0), 0};
    vecs[3]  = '{9'b1_000_00011, 0, 0, 1, mk(0, 0, 1, 0, 0, 4'd0, 4'd0), 0};
    vecs[4]  = '{9'b1_001_00000, 0, 0, 0, mk(0, 0, 1, 0, 0, 4'd0, 4'd0), 1};
    vecs[5]  = '{9'b1_001_00000, 0, 1, 1, mk(0, 0, 1, 0, 0, 4'd0, 4'd0), 0};
    vecs[6]  = '{9'b1_010_00000, 1, 0, 0, mk(0, 0, 1, 0, 0, 4'd0, 4'd0), 1};
    vecs[7]  = '{9'b1_010_00000, 0, 1, 0, mk(0, 0, 0, 0, 0, 4'd0, 4'd0), 0};
    vecs[8]  = '{9'b1_011_00000, 0, 0, 0, mk(0, 0, 1, 0, 0, 4'd0, 4'd0), 1};
    vecs[9]  = '{9'b1_101_00000, 1, 1, 0, mk(0, 0, 1, 0, 0, 4'd0, 4'd0), 1};
    vecs[10] = '{9'b1_101_00000, 0, 1, 0, mk(0, 0, 0, 0, 0, 4'd0, 4'd0), 0};
    vecs[11] = '{9'b1_110_00000, 0, 0, 0, mk(0, 0, 0, 0, 0, 4'd0, 4'd0), 0};
    vecs[12] = '{9'b1_110_00000, 0, 0, 1, mk(0, 0, 1, 0, 0, 4'd0, 4'd0), 0};
    vecs[13] = '{9'b1_100_00101, 0, 0, 0, mk(1, 0, 0, 1, 0, 4'd0, 4'd0), 0};
    vecs[14] = '{9'b1_111_00000, 1, 1, 1, mk(0, 0, 0, 0, 1, 4'd0, 4'd0), 0};
    vecs[15] = '{9'b0_1100_0111, 0, 0, 0, mk(1, 1, 0, 0, 0, 4'd7, 4'd0), 0};
    vecs[16] = '{9'b0_1101_1010, 0, 0, 0, mk(1, 1, 0, 0, 0, 4'd0, 4'd10), 0};
    vecs[17] = '{9'b0_1111_0011, 0, 0, 0, mk(1, 0, 0, 0, 0, 4'd0, 4'd3), 0};

    reset_n = 1'b0; inst_valid = 1'b0; inst = '0;
    z = 0; c = 0; n = 0; v = 0; mem_ack = 0;
    repeat (2) step();
    #3;
    check("reset", obs, 18'h0);
    reset_n = 1'b1;
    step();
    #3;
    check("idle_after_reset", obs, IDLE_V);

    foreach (vecs[k]) begin
      eu = vecs[k].exp;
      eu[11] = vecs[k].br_u;
      run_nonmem(vecs[k].inst, vecs[k].zf, vecs[k].nf, vecs[k].vf, vecs[k].exp, eu,
                 $sformatf("vec%0d", k));
    end

    // Load acknowledged on the third cycle after EXEC
    run_mem(9'b0_0000_0011, 2, "load_ack3");
    // Store never acknowledged: timeout
    run_mem(9'b0_0001_0010, 99, "store_timeout");
    // Acknowledge in the last allowed wait cycle beats the timeout
    run_mem(9'b0_0000_0110, T - 1, "load_last_ack");
    // Acknowledge arriving only in the error cycle is ignored
    run_mem(9'b0_0000_1001, T, "load_late_ack");

    // Acknowledge outside MEM_WAIT is ignored
    mem_ack = 1'b1;
    run_nonmem(9'b0_0011_0100, 0, 0, 0, mk(1, 0, 0, 0, 0, 4'd0, 4'd4),
               mk(1, 0, 0, 0, 0, 4'd0, 4'd4), "stray_ack");
    mem_ack = 1'b0;

    // Asynchronous reset in the middle of a load wait
    inst_valid = 1'b1;
    inst = 9'b0_0000_0101;
    step();
    inst_valid = 1'b0;
    step();
    #3;
    check("mw_before_reset", obs, model_mem(1'b1, 4'd5, 1'b0));
    reset_n = 1'b0;
    #1;
    check("reset_in_mw", obs, 18'h0);
    mem_ack = 1'b1;
    step();
    #3;
    check("reset_held", obs, 18'h0);
    mem_ack = 1'b0;
    reset_n = 1'b1;
    step();
    #3;
    check("ready_after_release", obs, IDLE_V);
    run_nonmem(9'b0_0110_0001, 0, 0, 0, mk(1, 0, 0, 0, 0, 4'd0, 4'd1),
               mk(1, 0, 0, 0, 0, 4'd0, 4'd1), "after_reset_op");

    // Randomized traffic against the model
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        ri = 9'($urandom);
        ri[8:5] = 4'b0000;
        run_mem(ri, $urandom_range(0, T + 1), $sformatf("rnd_mem%0d", it));
      end else begin
        ri = 9'($urandom);
        if (!ri[8] && ri[7:5] == 3'b000) ri[6] = 1'b1;
        rz = 1'($urandom); rn = 1'($urandom); rv = 1'($urandom);
        mem_ack = 1'($urandom);
        run_nonmem(ri, rz, rn, rv, model_exec(ri, rz, rn, rv, 1'b1),
                   model_exec(ri, rz, rn, rv, 1'b0), $sformatf("rnd%0d", it));
        mem_ack = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter INST_W, default 9: instruction width; SHALL satisfy INST_W >= REG_W+5.
REQ-002 Parameter REG_W, default 4: register-index width.
REQ-003 Parameter SIGNED_CMP, default 0: 0 = less-than is n; 1 = less-than is n XOR v.
REQ-004 Parameter TIMEOUT, default 16: max MEM_WAIT cycles before abort, >= 1.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 inst_valid  in  1  instruction offered; inst  in  INST_W  instruction word.
REQ-008 inst_ready  out  1  block accepts inst this cycle.
REQ-009 z, c, n, v  in  1 each  zero/carry/negative/overflow flags.
REQ-010 mem_ack  in  1  memory completed current request.
REQ-011 memory_read_en, memory_write_en, reg_write_en, reg_to_reg, branch_en, fetch_acc_en  out  1 each  datapath strobes.
REQ-012 reg_write_number, reg_from_number  out  REG_W  destination/source register index.
REQ-013 busy  out  1  state is not IDLE; illegal  out  1  undefined opcode pulse; mem_err  out  1  timeout pulse.

Function
REQ-014 States IDLE, EXEC, MEM_WAIT; inst_ready SHALL be 1 exactly in IDLE.
REQ-015 Accept on rising edge with IDLE & inst_valid: latch inst, go to EXEC; no accept otherwise.
REQ-016 Fields: cls=inst[INST_W-1]; bop=inst[INST_W-2 -: 3]; op=inst[INST_W-2 -: 4]; r=inst[REG_W-1:0].
REQ-017 All strobes, index outputs, illegal and mem_err SHALL be 0 in every cycle not explicitly driven by REQ-018..REQ-025.
REQ-018 EXEC, cls=1: bop 000 BLT (lt & ~z), 001 BGT (~lt & ~z), 010 BEQ (z), 011 always, 101 BGE (~lt | z), 110 BLE (lt | z) -> branch_en=1 if condition true; lt per SIGNED_CMP; flags sampled in EXEC cycle.
REQ-019 EXEC, cls=1, bop 100: fetch_acc_en=1, reg_write_en=1, reg_write_number=0.
REQ-020 EXEC, cls=1, bop 111: illegal=1 for one cycle, no other strobe.
REQ-021 EXEC, cls=0, op 1100: reg_write_en=1, reg_to_reg=1, reg_write_number=r, reg_from_number=0; op 1101: same with reg_write_number=0, reg_from_number=r.
REQ-022 EXEC, cls=0, other op except 0000/0001: reg_write_en=1, reg_write_number=0, reg_from_number=r.
REQ-023 EXEC, cls=0, op 0000 (LOAD): memory_read_en=1, reg_from_number=r, go to MEM_WAIT; op 0001 (STORE): memory_write_en=1, reg_from_number=r, go to MEM_WAIT.
REQ-024 MEM_WAIT: hold memory_*_en and reg_from_number; on mem_ack return to IDLE; LOAD asserts reg_write_en=1, reg_write_number=0 only in ack cycle.
REQ-025 MEM_WAIT counter starts at 0 on entry; if TIMEOUT cycles elapse without mem_ack: mem_err=1 one cycle, drop memory_*_en, no reg_write_en, return to IDLE; ack in the final cycle wins over timeout.
REQ-026 mem_ack outside MEM_WAIT SHALL be ignored.
REQ-027 All non-memory instructions take EXEC one cycle then IDLE: throughput one instruction per 2 cycles.
REQ-028 busy SHALL be 1 in EXEC and MEM_WAIT.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, clear latched inst and timeout counter, drive all strobes, indices, illegal, mem_err, busy to 0, independent of clk.
REQ-030 Reset during MEM_WAIT SHALL abandon the access with no reg_write_en; inst_ready=1 in the first cycle after release.

Verification
REQ-031 reset_n=0 while in MEM_WAIT with memory_read_en=1 -> all outputs 0 before next edge; after release inst_ready=1, busy=0.
REQ-032 INST_W=9, inst=0_0010_0101 accepted -> next cycle reg_write_en=1, reg_write_number=0, reg_from_number=5; then IDLE.
REQ-033 inst=1_000_00011: n=1,z=0 -> branch_en=1; n=1,z=1 -> 0; SIGNED_CMP=1, n=0,v=1 -> 1.
REQ-034 inst=0_0000_0011, mem_ack 3 cycles after EXEC -> memory_read_en high 4 cycles, reg_write_en=1 only in ack cycle, reg_from_number=3 throughout.
REQ-035 TIMEOUT=4, inst=0_0001_0010, mem_ack never -> mem_err=1 after 4 MEM_WAIT cycles, memory_write_en then 0, IDLE next.
REQ-036 inst=1_111_00000 -> illegal=1 one cycle, all write/branch strobes 0.
